// File: rtl/seq_mul.sv
// Sequential shift-add multiplier, one product bit per clock.
// Signed operands are multiplied as magnitudes and the sign is applied in a final FIX step,
// so the datapath is a single (WIDTH+1)-bit adder plus shifters.
module seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  OneCnt  = CntW'(1);
  localparam logic [WIDTH-1:0] OneW    = WIDTH'(1);
  localparam logic [PW-1:0]    OneP    = PW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             sgn_q;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    acc_shift;
  logic [PW-1:0]    acc_neg;

  // Operand magnitudes, one add-and-shift step, and the final sign fix-up.
  always_comb begin
    x_neg     = signed_mode & x[WIDTH-1];
    y_neg     = signed_mode & y[WIDTH-1];
    // Negating the most-negative value yields 2^(WIDTH-1), which is exact as unsigned.
    x_mag     = x_neg ? (~x + OneW) : x;
    y_mag     = y_neg ? (~y + OneW) : y;
    addend    = mplier_q[0] ? mcand_q : '0;
    sum       = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
    // {carry, acc} shifted right by one: the adder carry becomes the new MSB.
    acc_shift = {sum, acc_q[WIDTH-1:1]};
    acc_neg   = ~acc_q + OneP;
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= x_mag;
            mplier_q <= y_mag;
            sgn_q    <= signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= acc_shift;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + OneCnt;
          if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // A zero magnitude negates to zero, so no negative zero can appear.
          product <= sgn_q ? acc_neg : acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: WIDTH=8 instance checked every cycle against a cycle-count model,
// plus directed literal checks; WIDTH=4 instance swept exhaustively in both modes.
module tb_seq_mul;

  logic clk;
  logic rst_n;

  logic        start8;
  logic        s8;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;

  logic        start4;
  logic        s4;
  logic [3:0]  x4;
  logic [3:0]  y4;
  logic        busy4;
  logic        done4;
  logic [7:0]  prod4;

  int compared;
  int failed;

  seq_mul #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .signed_mode (s8),
    .x           (x8),
    .y           (y8),
    .busy        (busy8),
    .done        (done8),
    .product     (prod8)
  );

  seq_mul #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start4),
    .signed_mode (s4),
    .x           (x4),
    .y           (y4),
    .busy        (busy4),
    .done        (done4),
    .product     (prod4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference products from plain integer arithmetic.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ia;
    int ib;
    int p;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[15:0];
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia;
    int ib;
    int p;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[7:0];
  endfunction

  // Transaction-level model of the 8-bit unit: accept when idle, deliver WIDTH+1 edges later.
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_prod;
  logic [15:0] m_exp;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_exp  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start8) begin
          m_exp  <= ref8(x8, y8, s8);
          m_busy <= 1'b1;
          m_left <= 9;
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_exp;
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // Cycle-by-cycle comparison of the 8-bit unit against the model.
  always @(negedge clk) begin
    compared++;
    if ({busy8, done8, prod8} !== {m_busy, m_done, m_prod}) begin
      failed++;
      $display("FAIL model_cycle t=%0t: got busy=%b done=%b product=%h, expected busy=%b done=%b product=%h",
               $time, busy8, done8, prod8, m_busy, m_done, m_prod);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at the negedge following the start edge; returns cycles until done is seen.
  task automatic wait_done8(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done8 && n < 20) begin
      if (busy8) nb++;
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("done8_timeout", 32'(n), 32'd9);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string name);
    int n;
    int nb;
    @(negedge clk);
    start8 = 1'b1;
    x8     = a;
    y8     = b;
    s8     = s;
    @(negedge clk);
    start8 = 1'b0;
    // Operand changes outside the start edge must not matter.
    x8     = 8'($urandom);
    y8     = 8'($urandom);
    s8     = ~s;
    wait_done8(n, nb);
    check({name, "_latency"}, 32'(n), 32'd9);
    check({name, "_busy_cycles"}, 32'(nb), 32'd9);
    check({name, "_product"}, 32'(prod8), 32'(exp));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [7:0] exp, input string name);
    int n;
    @(negedge clk);
    start4 = 1'b1;
    x4     = a;
    y4     = b;
    s4     = s;
    @(negedge clk);
    start4 = 1'b0;
    n      = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 20 || prod4 !== exp) begin
      failed++;
      $display("FAIL %s x=%h y=%h s=%b: got %h (after %0d cycles) expected %h",
               name, a, b, s, prod4, n, exp);
    end
  endtask

  initial begin
    int  n;
    int  nb;
    bit  seen;
    compared = 0;
    failed   = 0;
    rst_n    = 1'b0;
    start8   = 1'b0;
    s8       = 1'b0;
    x8       = '0;
    y8       = '0;
    start4   = 1'b0;
    s4       = 1'b0;
    x4       = '0;
    y4       = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_product", 32'(prod8), 32'd0);
    rst_n = 1'b1;

    // Unsigned and signed directed cases.
    op8(8'd13,  8'd11,  1'b0, 16'h008F, "u_13x11");
    op8(8'd255, 8'd255, 1'b0, 16'hFE01, "u_255x255");
    op8(8'h80,  8'h80,  1'b1, 16'h4000, "s_min_x_min");
    op8(8'hFD,  8'h05,  1'b1, 16'hFFF1, "s_m3x5");
    op8(8'h00,  8'h80,  1'b1, 16'h0000, "s_0xmin");
    op8(8'h80,  8'h7F,  1'b1, 16'hC080, "s_min_x_max");

    // Handshake: start while busy ignored, then back-to-back start on the done cycle.
    @(negedge clk);
    start8 = 1'b1;
    x8     = 8'd7;
    y8     = 8'd6;
    s8     = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1;
    x8     = 8'd9;
    y8     = 8'd9;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(n, nb);
    check("hs_first_product", 32'(prod8), 32'h002A);
    start8 = 1'b1;
    x8     = 8'd2;
    y8     = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    check("hs_busy_no_gap", 32'(busy8), 32'd1);
    check("hs_done_dropped", 32'(done8), 32'd0);
    wait_done8(n, nb);
    check("hs_second_latency", 32'(n), 32'd9);
    check("hs_second_product", 32'(prod8), 32'h0006);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start8 = 1'b1;
    x8     = 8'd100;
    y8     = 8'd100;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_product", 32'(prod8), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    rst_n = 1'b1;
    op8(8'd3, 8'd4, 1'b0, 16'h000C, "post_reset_3x4");

    // WIDTH=4: literal anchor, then exhaustive sweep in both modes.
    op4(4'd15, 4'd15, 1'b0, 8'hE1, "w4_15x15");
    op4(4'h8,  4'h8,  1'b1, 8'h40, "w4_smin_x_smin");
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          op4(4'(a), 4'(b), 1'(s), ref4(4'(a), 4'(b), 1'(s)), "w4_sweep");
        end
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the fixed 4x4 combinational array multiplier in the COMBINATIONAL library.
- Width is generic.
- Mode is selectable per operation: unsigned or two's-complement signed.
- One product bit-step per clock, so area stays small at large widths.
- A start/busy/done handshake lets a controller issue back-to-back operations.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new multiply; honoured only when busy=0.
signed_mode  input  1  1: operands are two's complement; 0: unsigned. Sampled with start.
x  input  WIDTH  multiplicand, sampled with start.
y  input  WIDTH  multiplier, sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when product is updated.
product  output  2*WIDTH  result; holds its value until the next completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - busy=0, done=0, product=0, all internal registers 0, FSM=IDLE.
  - Release of reset takes effect synchronously on the next clk edge.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1, latch the operands and mode.
  - Magnitudes: in signed mode, |x| and |y| (the negative magnitude of the most-negative value fits in WIDTH bits unsigned). In unsigned mode, x and y as given.
  - Sign flag: sgn = signed_mode & (x[MSB]^y[MSB]).
  - Clear the accumulator and iteration counter, set busy=1, go to RUN.
- RUN, one iteration per edge, WIDTH edges total:
  - If multiplier LSB=1, add multiplicand to the upper half of the accumulator; the carry is kept in a (WIDTH+1)-bit adder.
  - Shift the {carry, accumulator} pair right 1.
  - Shift the multiplier right 1.
  - Counter counts 0..WIDTH-1; on the edge where counter=WIDTH-1, go to FIX.
- FIX, one edge:
  - product <= sgn ? two's-complement negation of the accumulator : accumulator (2*WIDTH bits).
  - done=1 for exactly that cycle, busy=0, go to IDLE.
- Latency: start sampled at edge 0 → done high and product valid after edge WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- Start while busy=1: ignored. Operands, mode and the in-flight result are unaffected, and there is no queuing.
- Start in the cycle done=1 (FSM in IDLE): accepted, giving back-to-back operation. done deasserts on that edge and busy reasserts.
- Operands of zero: the full WIDTH iterations still run (fixed latency, no early exit). Result is 0, and there is no negative zero.
- Signed corners:
  - (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = +2^(2*WIDTH-2), which fits in the signed result.
  - (-2^(WIDTH-1)) * (2^(WIDTH-1)-1) is exact.
  - No overflow is possible in either mode.
- Changes on x, y and signed_mode outside the start edge have no effect.
- Reset asserted mid-operation: the operation is aborted immediately and all outputs return to reset values. No done pulse is generated for the aborted operation.
- Arithmetic is purely bit-level: AND/add/shift. No vendor multiplier primitives.

Test Plan:
- WIDTH=8, unsigned: x=13, y=11, start 1 cycle → done pulse exactly 9 cycles after start edge, product=0x008F; busy high for 9 cycles between.
- WIDTH=8, unsigned: x=255, y=255 → product=0xFE01.
- WIDTH=8, signed cases:
  - x=0x80, y=0x80 → product=0x4000.
  - x=0xFD (-3), y=0x05 → product=0xFFF1.
  - x=0x00, y=0x80 → product=0x0000.
- WIDTH=8, handshake:
  - Start x=7, y=6; pulse start with x=9, y=9 three cycles later → the second start is ignored; product=0x002A.
  - Then assert start on the done cycle with x=2, y=3 → product=0x0006 after another 9 cycles.
  - No idle gap in busy between the two operations.
- WIDTH=8, reset: start x=100, y=100; drop rst_n asynchronously mid-clock on cycle 4 → busy, done and product go 0 immediately, no done pulse. After release, start x=3, y=4 → product=0x000C.
- WIDTH=4, equivalence sweep: exhaustive unsigned 16x16 sweep matching the legacy 4x4 array multiplier (e.g. 15*15 → 0xE1); exhaustive signed 16x16 against a reference model.
